seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digits (legal range 2..8).
REQ-002 Parameter ON_CYCLES, default 25000, SHALL set the number of clocks each digit anode is driven.
REQ-003 Parameter SETTLE_CYCLES, default 2, SHALL set the anodes-off clocks before each digit (minimum 2, covering the 1-clock registered decoder latency).
REQ-004 i_Clk  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-005 i_Rst_L  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 i_Enable  in  1  SHALL enable scanning when high.
REQ-007 i_Load  in  1  SHALL be a single-cycle strobe that captures i_Values into the shadow register.
REQ-008 i_Values  in  4*NUM_DIGITS  SHALL hold the nibbles, with digit k at bits [4k+3:4k].
REQ-009 i_Blank_Mask  in  NUM_DIGITS  SHALL suppress anode k when bit k is 1; it is sampled live.
REQ-010 o_Nibble  out  4  SHALL be the nibble driven to the shared registered hex-to-7-segment decoder.
REQ-011 o_Digit_N  out  NUM_DIGITS  SHALL be the active-low one-hot anode enables, registered.
REQ-012 o_Digit_Idx  out  clog2(NUM_DIGITS)  SHALL be the index of the digit currently scanned.
REQ-013 o_Frame_Done  out  1  SHALL pulse high for one clock at the end of each full frame.

Function
REQ-014 The FSM SHALL have three states: IDLE, SETTLE and ON, plus a dwell counter sized for max(ON_CYCLES, SETTLE_CYCLES).
REQ-015 In IDLE with i_Enable=1, the FSM SHALL enter SETTLE on the next clock with idx=0 and counter=0.
REQ-016 In SETTLE:
- o_Digit_N SHALL be all ones.
- o_Nibble SHALL equal the active nibble for idx.
- After SETTLE_CYCLES clocks the FSM SHALL enter ON.
REQ-017 In ON:
- o_Digit_N[idx] SHALL be 0 unless i_Blank_Mask[idx]=1; all other bits SHALL be 1.
- o_Nibble SHALL be held.
- After ON_CYCLES clocks the FSM SHALL enter SETTLE.
REQ-018 On leaving ON, idx SHALL increment, and wrap from NUM_DIGITS-1 to 0.
REQ-019 On the ON to SETTLE transition with idx=NUM_DIGITS-1 (the frame boundary):
- o_Frame_Done SHALL be 1 for exactly that clock.
- If the pending flag is set, shadow SHALL be copied to active and pending SHALL clear.
REQ-020 i_Load SHALL write i_Values into shadow and set pending, in any state.
REQ-021 If i_Load coincides with a frame boundary, the value loaded that cycle SHALL be the one copied to active.
REQ-022 In IDLE, a pending shadow SHALL be copied to active on the next clock.
REQ-023 Active digit values SHALL never change mid-frame (no tearing).
REQ-024 When i_Enable=0 in SETTLE or ON, the FSM SHALL go to IDLE on the next clock:
- o_Digit_N all ones, idx=0, counter=0.
- o_Frame_Done SHALL NOT pulse.
REQ-025 Frame length SHALL be exactly NUM_DIGITS*(SETTLE_CYCLES+ON_CYCLES) clocks.
REQ-026 The counter SHALL reset to 0 on every state change; a counter terminal count SHALL NOT carry over.

Reset
REQ-027 On i_Rst_L=0, all of the following SHALL hold immediately and independent of i_Clk:
- state=IDLE.
- o_Digit_N all ones, o_Nibble=0, o_Digit_Idx=0, o_Frame_Done=0.
- shadow=0, active=0, pending=0, counter=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no o_Frame_Done pulse.
REQ-029 After release, the first frame SHALL start from idx 0 in SETTLE, one clock after i_Enable is seen high.

Verification
All scenarios use NUM_DIGITS=4, ON_CYCLES=4, SETTLE_CYCLES=2.
REQ-030 Basic scan:
- Stimulus: load 16'h4321, enable.
- Required: o_Digit_N steps 1110, 1101, 1011, 0111 per digit, each low for 4 clocks after 2 clocks all-ones; o_Nibble steps 1, 2, 3, 4.
- Required: o_Frame_Done every 24 clocks.
REQ-031 Anti-tear:
- Stimulus: load 16'hAAAA mid-frame of 16'h4321.
- Required: the remaining digits still show 3, 4; the next frame shows A, A, A, A.
REQ-032 Boundary coincidence:
- Stimulus: i_Load with 16'hBEEF in the o_Frame_Done cycle.
- Required: the next frame shows F, E, E, B.
REQ-033 Blanking:
- Stimulus: i_Blank_Mask=4'b0101.
- Required: o_Digit_N bits 0 and 2 are never low; timing and o_Frame_Done are unchanged.
REQ-034 Disable and reset:
- Stimulus: drop i_Enable during digit 2 ON.
- Required: all anodes off next clock, idx=0, no o_Frame_Done.
- Stimulus: assert i_Rst_L=0 asynchronously mid-SETTLE.
- Required: outputs go to reset values before the next edge.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// Bus bundle for the multiplexed seven-segment scanner.
//   i_Enable      scanning enable
//   i_Load        one-cycle strobe, captures i_Values into the shadow register
//   i_Values      digit k nibble at [4k+3:4k]
//   i_Blank_Mask  bit k high suppresses anode k (sampled live)
//   o_Nibble      nibble feeding the shared registered hex-to-7-seg decoder
//   o_Digit_N     active-low one-hot anode enables (registered)
//   o_Digit_Idx   index of the digit being scanned
//   o_Frame_Done  one-clock pulse on the last clock of each frame
// master drives the inputs (controller/bench), slave is the scanner.
interface seven_seg_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    i_Enable;
  logic                    i_Load;
  logic [4*NUM_DIGITS-1:0] i_Values;
  logic [NUM_DIGITS-1:0]   i_Blank_Mask;
  logic [3:0]              o_Nibble;
  logic [NUM_DIGITS-1:0]   o_Digit_N;
  logic [IW-1:0]           o_Digit_Idx;
  logic                    o_Frame_Done;

  modport master (
    output i_Enable, i_Load, i_Values, i_Blank_Mask,
    input  o_Nibble, o_Digit_N, o_Digit_Idx, o_Frame_Done
  );

  modport slave (
    input  i_Enable, i_Load, i_Values, i_Blank_Mask,
    output o_Nibble, o_Digit_N, o_Digit_Idx, o_Frame_Done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display scanner.
//
// Each digit gets SETTLE_CYCLES clocks with every anode off (lets the
// registered decoder catch up with the new nibble), then ON_CYCLES clocks
// with its anode driven. A frame is NUM_DIGITS*(SETTLE_CYCLES+ON_CYCLES)
// clocks. New values land in a shadow register and are only promoted to the
// displayed (active) set at a frame boundary or while idle, so a frame never
// shows a mix of old and new digits.
//
// Ports:
//   i_Clk    clock, rising edge
//   i_Rst_L  asynchronous active-low reset
//   bus      seven_seg_scanner_if.slave (enable/load/values/mask in,
//            nibble/anodes/index/frame-done out)

// Per-digit storage: shadow + active nibble and the registered anode bit.
//   load     write value into shadow
//   commit   promote into active; bypass selects the live value over shadow
//   drive    this digit's anode is due to be on next clock
//   blank    live blanking for this digit
module seven_seg_lane (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       load,
  input  logic [3:0] value,
  input  logic       commit,
  input  logic       bypass,
  input  logic       drive,
  input  logic       blank,
  output logic [3:0] active,
  output logic       digit_n
);
  logic [3:0] shadow;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      shadow  <= '0;
      active  <= '0;
      digit_n <= 1'b1;
    end else begin
      if (load)   shadow <= value;
      // bypass covers a load landing in the frame-boundary cycle: the value
      // on the bus that cycle is the one that must be displayed next.
      if (commit) active <= bypass ? value : shadow;
      digit_n <= ~(drive & ~blank);
    end
  end
endmodule

module seven_seg_scanner #(
  parameter int NUM_DIGITS    = 4,
  parameter int ON_CYCLES     = 25000,
  parameter int SETTLE_CYCLES = 2
) (
  input logic            i_Clk,
  input logic            i_Rst_L,
  seven_seg_scanner_if.slave bus
);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAXC = (ON_CYCLES > SETTLE_CYCLES) ? ON_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ON     = 2'd2
  } state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              cnt, cnt_nxt;
  logic [IW-1:0]              idx, idx_nxt;
  logic                       pending;
  logic                       boundary;
  logic                       commit;
  logic                       bypass;
  logic [NUM_DIGITS-1:0]      drive;
  logic [NUM_DIGITS-1:0]      digit_n;
  logic [NUM_DIGITS-1:0][3:0] values;
  logic [NUM_DIGITS-1:0][3:0] active;

  assign values = bus.i_Values;

  // Last clock of the last digit's ON window; dropping enable here aborts
  // the frame instead of completing it.
  assign boundary = (state == ON) && (cnt == CW'(ON_CYCLES - 1)) &&
                    (idx == IW'(NUM_DIGITS - 1)) && bus.i_Enable;

  // Promotion points: frame boundary (pending or same-cycle load), or any
  // idle clock with something pending.
  assign commit = (boundary && (pending || bus.i_Load)) ||
                  ((state == IDLE) && pending);
  assign bypass = boundary && bus.i_Load;

  // ---------------- state register ----------------
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // ---------------- next state ----------------
  // The counter restarts on every state change so a terminal count never
  // leaks into the next phase.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (bus.i_Enable) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!bus.i_Enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          state_nxt = ON;
          cnt_nxt   = '0;
        end
      end
      ON: begin
        if (!bus.i_Enable) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (cnt == CW'(ON_CYCLES - 1)) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
          idx_nxt   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Anodes are registered from the next state so they line up with the
  // state register rather than trailing it by a clock.
  always_comb begin
    drive = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      drive[k] = (state_nxt == ON) && (idx_nxt == IW'(k));
  end

  // ---------------- pending flag ----------------
  // A load in the boundary cycle is consumed immediately by the bypass.
  // An idle commit that coincides with a load leaves the new value pending
  // for the following clock.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      pending <= 1'b0;
    else if (boundary)
      pending <= 1'b0;
    else if (bus.i_Load)
      pending <= 1'b1;
    else if (state == IDLE)
      pending <= 1'b0;
  end

  // ---------------- per-digit lanes ----------------
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
    seven_seg_lane u_lane (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .load    (bus.i_Load),
      .value   (values[k]),
      .commit  (commit),
      .bypass  (bypass),
      .drive   (drive[k]),
      .blank   (bus.i_Blank_Mask[k]),
      .active  (active[k]),
      .digit_n (digit_n[k])
    );
  end

  // ---------------- outputs ----------------
  // Active values are frozen for the whole frame, so the mux output is
  // stable through SETTLE and ON of each digit.
  assign bus.o_Nibble     = active[idx];
  assign bus.o_Digit_N    = digit_n;
  assign bus.o_Digit_Idx  = idx;
  assign bus.o_Frame_Done = boundary;
endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;
  localparam int N   = 4;
  localparam int ONC = 4;
  localparam int S   = 2;
  localparam int PER = S + ONC;
  localparam int F   = N * PER;

  logic clk;
  logic rst_n;
  int   n_asrt = 0;
  int   n_fail = 0;

  seven_seg_scanner_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scanner #(
    .NUM_DIGITS    (N),
    .ON_CYCLES     (ONC),
    .SETTLE_CYCLES (S)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: position within the frame, with frozen displayed values.
  bit          m_run;
  int          m_p;
  logic [15:0] m_shadow, m_active;
  bit          m_pending;
  logic [3:0]  m_mask;
  int          fd_seen;
  bit          cap_on;
  logic [3:0]  capq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_p = 0; m_shadow = '0; m_active = '0; m_pending = 0; m_mask = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_digit_n"}, 32'(bus.o_Digit_N), 32'hF);
    check({tag, "_nibble"},  32'(bus.o_Nibble), 32'h0);
    check({tag, "_idx"},     32'(bus.o_Digit_Idx), 32'h0);
    check({tag, "_fdone"},   32'(bus.o_Frame_Done), 32'h0);
  endtask

  task automatic compare();
    int d, ph;
    logic [3:0] edn;
    d   = m_p / PER;
    ph  = m_p % PER;
    edn = 4'hF;
    if (m_run && ph >= S && !m_mask[d]) edn[d] = 1'b0;
    check("digit_n", 32'(bus.o_Digit_N), 32'(edn));
    check("digit_idx", 32'(bus.o_Digit_Idx), m_run ? 32'(d) : 32'd0);
    check("frame_done", 32'(bus.o_Frame_Done), 32'(m_run && m_p == F - 1 && bus.i_Enable));
    if (m_run) check("nibble", 32'(bus.o_Nibble), 32'(m_active[d*4 +: 4]));
    if (bus.o_Frame_Done) fd_seen++;
    if (cap_on && m_run && ph == S) capq.push_back(bus.o_Nibble);
  endtask

  // One clock: sample inputs as the DUT sees them, advance the model, check.
  task automatic tick();
    logic        en, ld;
    logic [15:0] v;
    logic [3:0]  mk;
    bit          bnd;
    en = bus.i_Enable; ld = bus.i_Load; v = bus.i_Values; mk = bus.i_Blank_Mask;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      bnd = m_run && (m_p == F - 1) && en;
      if (bnd) begin
        if (ld) m_active = v;
        else if (m_pending) m_active = m_shadow;
        m_pending = 0;
      end else if (!m_run && m_pending) begin
        m_active  = m_shadow;
        m_pending = ld;
      end else if (ld) begin
        m_pending = 1;
      end
      if (ld) m_shadow = v;
      if (!en) begin
        m_run = 0; m_p = 0;
      end else if (!m_run) begin
        m_run = 1; m_p = 0;
      end else begin
        m_p = (m_p + 1) % F;
      end
      m_mask = mk;
    end
    #1;
    compare();
  endtask

  task automatic check_caps(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                            input logic [3:0] e2, input logic [3:0] e3);
    logic [3:0] e[4];
    e = '{e0, e1, e2, e3};
    check({tag, "_count"}, 32'(capq.size()), 32'd4);
    for (int i = 0; i < 4; i++) check({tag, "_digit"}, 32'(capq[i]), 32'(e[i]));
  endtask

  initial begin
    model_reset();
    fd_seen = 0; cap_on = 0;
    bus.i_Enable = 1'b0; bus.i_Load = 1'b0; bus.i_Values = '0; bus.i_Blank_Mask = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (3) tick();
    #3 rst_n = 1'b1;
    tick();

    // Basic scan: load then enable
    bus.i_Load = 1'b1; bus.i_Values = 16'h4321;
    tick();
    bus.i_Load = 1'b0; bus.i_Enable = 1'b1;
    tick();
    capq.delete(); cap_on = 1;
    repeat (F - 1) tick();
    cap_on = 0;
    check_caps("scan", 4'h1, 4'h2, 4'h3, 4'h4);
    fd_seen = 0;
    repeat (2 * F) tick();
    check("scan_frames", 32'(fd_seen), 32'd2);

    // Anti-tear: load during digit 1 ON
    for (int i = 0; i < 100 && !(m_run && m_p == 9); i++) tick();
    check("reach_tear", 32'(m_run && m_p == 9), 32'd1);
    bus.i_Load = 1'b1; bus.i_Values = 16'hAAAA;
    tick();
    bus.i_Load = 1'b0;
    capq.delete(); cap_on = 1;
    for (int i = 0; i < 100 && !(m_p == F - 1); i++) tick();
    check("tear_rest", 32'(capq.size()), 32'd2);
    check("tear_d2", 32'(capq[0]), 32'h3);
    check("tear_d3", 32'(capq[1]), 32'h4);
    capq.delete();
    repeat (F) tick();
    cap_on = 0;
    check_caps("tear_next", 4'hA, 4'hA, 4'hA, 4'hA);

    // Load in the frame-done cycle
    for (int i = 0; i < 100 && !(m_run && m_p == F - 1); i++) tick();
    check("reach_bnd", 32'(bus.o_Frame_Done), 32'd1);
    bus.i_Load = 1'b1; bus.i_Values = 16'hBEEF;
    tick();
    bus.i_Load = 1'b0;
    capq.delete(); cap_on = 1;
    repeat (F - 1) tick();
    cap_on = 0;
    check_caps("bnd", 4'hF, 4'hE, 4'hE, 4'hB);

    // Blanking
    bus.i_Blank_Mask = 4'b0101;
    fd_seen = 0;
    repeat (F) tick();
    check("blank_frames", 32'(fd_seen), 32'd1);
    bus.i_Blank_Mask = 4'b0000;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.i_Load   = ($urandom_range(15) == 0);
      bus.i_Values = 16'($urandom);
      if ($urandom_range(15) == 0) bus.i_Blank_Mask = 4'($urandom);
      bus.i_Enable = ($urandom_range(40) != 0);
      tick();
    end
    bus.i_Load = 1'b0; bus.i_Blank_Mask = '0; bus.i_Enable = 1'b1;

    // Disable during digit 2 ON
    for (int i = 0; i < 100 && !(m_run && m_p == 2 * PER + S + 1); i++) tick();
    check("reach_dis", 32'(m_run && m_p == 2 * PER + S + 1), 32'd1);
    bus.i_Enable = 1'b0;
    fd_seen = 0;
    tick();
    check("dis_anodes", 32'(bus.o_Digit_N), 32'hF);
    check("dis_idx", 32'(bus.o_Digit_Idx), 32'h0);
    repeat (3) tick();
    check("dis_nofd", 32'(fd_seen), 32'd0);
    bus.i_Enable = 1'b1;

    // Async reset mid-SETTLE
    for (int i = 0; i < 100 && !(m_run && m_p == PER); i++) tick();
    check("reach_rst", 32'(m_run && m_p == PER), 32'd1);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_reset("async");
    repeat (2) tick();
    #3 rst_n = 1'b1;
    fd_seen = 0;
    repeat (F + 6) tick();
    check("post_rst_frames", 32'(fd_seen), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
